// File: rtl/iq_issue_select_if.sv
// Issue-select bundle: IQ extraction window, consumed strobes,
// registered issue lanes, writeback clears and flush.
interface iq_issue_select_if #(
   parameter int EXT_COUNT   = 4,
   parameter int ISSUE_WIDTH = 2,
   parameter int WB_COUNT    = 2,
   parameter int ROB_W       = 4
);
   logic [EXT_COUNT-1:0]   win_valid;
   logic [4:0]             win_src_a [EXT_COUNT];
   logic [4:0]             win_src_b [EXT_COUNT];
   logic [4:0]             win_dest [EXT_COUNT];
   logic [EXT_COUNT-1:0]   win_use_a;
   logic [EXT_COUNT-1:0]   win_use_b;
   logic [EXT_COUNT-1:0]   win_wr;
   logic [1:0]             win_class [EXT_COUNT];
   logic [EXT_COUNT-1:0]   win_stream;
   logic [ROB_W-1:0]       win_rob_slot [EXT_COUNT];
   logic [EXT_COUNT-1:0]   ext_consumed;
   logic                   ext_enable;
   logic [ISSUE_WIDTH-1:0] issue_valid;
   logic [4:0]             issue_src_a [ISSUE_WIDTH];
   logic [4:0]             issue_src_b [ISSUE_WIDTH];
   logic [4:0]             issue_dest [ISSUE_WIDTH];
   logic [ISSUE_WIDTH-1:0] issue_use_a;
   logic [ISSUE_WIDTH-1:0] issue_use_b;
   logic [ISSUE_WIDTH-1:0] issue_wr;
   logic [1:0]             issue_class [ISSUE_WIDTH];
   logic [ISSUE_WIDTH-1:0] issue_stream;
   logic [ROB_W-1:0]       issue_rob_slot [ISSUE_WIDTH];
   logic                   issue_ready;
   logic [WB_COUNT-1:0]    wb_valid;
   logic [4:0]             wb_reg [WB_COUNT];
   logic                   flush;
   logic                   flush_stream;

   modport master (
      output win_valid, win_src_a, win_src_b, win_dest,
      output win_use_a, win_use_b, win_wr, win_class,
      output win_stream, win_rob_slot,
      input  ext_consumed, ext_enable,
      input  issue_valid, issue_src_a, issue_src_b,
      input  issue_dest, issue_use_a, issue_use_b,
      input  issue_wr, issue_class, issue_stream,
      input  issue_rob_slot,
      output issue_ready, wb_valid, wb_reg,
      output flush, flush_stream
   );

   modport slave (
      input  win_valid, win_src_a, win_src_b, win_dest,
      input  win_use_a, win_use_b, win_wr, win_class,
      input  win_stream, win_rob_slot,
      output ext_consumed, ext_enable,
      output issue_valid, issue_src_a, issue_src_b,
      output issue_dest, issue_use_a, issue_use_b,
      output issue_wr, issue_class, issue_stream,
      output issue_rob_slot,
      input  issue_ready, wb_valid, wb_reg,
      input  flush, flush_stream
   );
endinterface

// File: rtl/iq_issue_select.sv
// Issue select: picks up to ISSUE_WIDTH hazard-free window slots,
// registers them on issue lanes and owns the busy scoreboard.
module iq_issue_select #(
   parameter int EXT_COUNT   = 4,
   parameter int ISSUE_WIDTH = 2,
   parameter int WB_COUNT    = 2,
   parameter int ROB_W       = 4
) (
   input logic              clock,
   input logic              reset_n,
   iq_issue_select_if.slave bus
);
   typedef struct packed {
      logic [4:0]       src_a;
      logic [4:0]       src_b;
      logic [4:0]       dest;
      logic             use_a;
      logic             use_b;
      logic             wr;
      logic [1:0]       cls;
      logic             stream;
      logic [ROB_W-1:0] rob_slot;
   } uop_t;

   uop_t                   win [EXT_COUNT];
   uop_t                   lane [ISSUE_WIDTH];
   uop_t                   lane_nxt [ISSUE_WIDTH];
   logic [ISSUE_WIDTH-1:0] lane_v;
   logic [ISSUE_WIDTH-1:0] lane_vn;
   logic [EXT_COUNT-1:0]   cand;
   logic [EXT_COUNT-1:0]   sel;
   logic [31:0]            busy;
   logic [31:0]            busy_nxt;
   logic [31:0]            wb_hit;
   logic [31:0]            rdy;
   logic [31:0]            clr;
   logic [31:0]            set;
   logic                   accept;

   // older o vs younger y: RAW, WAW or WAR on a nonzero register
   function automatic logic hazard(input uop_t o, input uop_t y);
      logic raw, waw, war;
      raw = o.wr && (o.dest != 5'd0) &&
            ((y.use_a && y.src_a == o.dest) ||
             (y.use_b && y.src_b == o.dest));
      waw = o.wr && y.wr && (o.dest != 5'd0) &&
            (o.dest == y.dest);
      war = y.wr && (y.dest != 5'd0) &&
            ((o.use_a && o.src_a == y.dest) ||
             (o.use_b && o.src_b == y.dest));
      return raw || waw || war;
   endfunction

   assign accept = bus.issue_ready && !bus.flush;
   assign rdy    = ~busy | wb_hit;

   // gather window slots into one record each
   always_comb begin
      for (int i = 0; i < EXT_COUNT; i++) begin
         win[i].src_a    = bus.win_src_a[i];
         win[i].src_b    = bus.win_src_b[i];
         win[i].dest     = bus.win_dest[i];
         win[i].use_a    = bus.win_use_a[i];
         win[i].use_b    = bus.win_use_b[i];
         win[i].wr       = bus.win_wr[i];
         win[i].cls      = bus.win_class[i];
         win[i].stream   = bus.win_stream[i];
         win[i].rob_slot = bus.win_rob_slot[i];
      end
   end

   // registers being written back this cycle (bypass and clear)
   always_comb begin
      wb_hit = '0;
      for (int w = 0; w < WB_COUNT; w++)
         if (bus.wb_valid[w])
            wb_hit[bus.wb_reg[w]] = 1'b1;
   end

   // candidate = valid, operands ready, dest free, no older hazard
   always_comb begin
      for (int i = 0; i < EXT_COUNT; i++) begin
         cand[i] = bus.win_valid[i];
         if (win[i].use_a && !rdy[win[i].src_a])
            cand[i] = 1'b0;
         if (win[i].use_b && !rdy[win[i].src_b])
            cand[i] = 1'b0;
         if (win[i].wr && busy[win[i].dest])
            cand[i] = 1'b0;
         for (int j = 0; j < EXT_COUNT; j++)
            if (j < i && bus.win_valid[j] && hazard(win[j], win[i]))
               cand[i] = 1'b0;
      end
   end

   // in-order scan under lane and MEM/BR unit limits
   always_comb begin
      int   n;
      logic mem_used, br_used, is_mem, is_br, take;
      sel      = '0;
      lane_vn  = '0;
      n        = 0;
      mem_used = 1'b0;
      br_used  = 1'b0;
      for (int l = 0; l < ISSUE_WIDTH; l++)
         lane_nxt[l] = '0;
      for (int i = 0; i < EXT_COUNT; i++) begin
         is_mem = (win[i].cls == 2'd1);
         is_br  = (win[i].cls == 2'd2);
         unique case (1'b1)
            is_mem:  take = cand[i] && !mem_used;
            is_br:   take = cand[i] && !br_used;
            default: take = cand[i];
         endcase
         if (n >= ISSUE_WIDTH)
            take = 1'b0;
         if (take) begin
            sel[i] = 1'b1;
            for (int l = 0; l < ISSUE_WIDTH; l++)
               if (l == n) begin
                  lane_nxt[l] = win[i];
                  lane_vn[l]  = 1'b1;
               end
            n        = n + 1;
            mem_used = mem_used | is_mem;
            br_used  = br_used | is_br;
         end
      end
   end

   // scoreboard next: clears from writeback/flush, set on issue wins
   always_comb begin
      clr = wb_hit;
      set = '0;
      for (int l = 0; l < ISSUE_WIDTH; l++)
         if (bus.flush && lane_v[l] && lane[l].wr &&
             lane[l].stream == bus.flush_stream)
            clr[lane[l].dest] = 1'b1;
      for (int i = 0; i < EXT_COUNT; i++)
         if (accept && sel[i] && win[i].wr)
            set[win[i].dest] = 1'b1;
      busy_nxt = ((busy & ~clr) | set) & ~32'd1;
   end

   // busy scoreboard register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   // issue lanes: load on accept, drop or clear on flush
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lane_v <= '0;
         for (int l = 0; l < ISSUE_WIDTH; l++)
            lane[l] <= '0;
      end else begin
         for (int l = 0; l < ISSUE_WIDTH; l++) begin
            if (bus.flush) begin
               if (lane_v[l] && lane[l].stream == bus.flush_stream) begin
                  lane_v[l] <= 1'b0;
               end else if (bus.issue_ready) begin
                  lane_v[l] <= 1'b0;
                  lane[l]   <= '0;
               end
            end else if (bus.issue_ready) begin
               lane_v[l] <= lane_vn[l];
               lane[l]   <= lane_nxt[l];
            end
         end
      end
   end

   assign bus.ext_consumed = sel & {EXT_COUNT{accept}};
   assign bus.ext_enable   = accept;
   assign bus.issue_valid  = lane_v;

   // spread lane records onto the outgoing bundle
   always_comb begin
      for (int l = 0; l < ISSUE_WIDTH; l++) begin
         bus.issue_src_a[l]    = lane[l].src_a;
         bus.issue_src_b[l]    = lane[l].src_b;
         bus.issue_dest[l]     = lane[l].dest;
         bus.issue_use_a[l]    = lane[l].use_a;
         bus.issue_use_b[l]    = lane[l].use_b;
         bus.issue_wr[l]       = lane[l].wr;
         bus.issue_class[l]    = lane[l].cls;
         bus.issue_stream[l]   = lane[l].stream;
         bus.issue_rob_slot[l] = lane[l].rob_slot;
      end
   end
endmodule
